// File: rtl/pixel_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixel_scheduler: per-solver frame walker issuing coordinates to an       |
// | escape-time solver and streaming (addr, value) results. Optional macro:  |
// | PIXEL_SCHEDULER_SATURATE_EN saturates the pixel value.                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pixel_scheduler #(
  parameter int COORD_W     = 27,
  parameter int ITER_W      = 32,
  parameter int RESULT_W    = 4,
  parameter int VALUE_SHIFT = 6,
  parameter int NUM_COLUMNS = 640,
  parameter int NUM_ROWS    = 480,
  parameter int NUM_SOLVERS = 1,
  parameter int SOLVER_ID   = 0,
  parameter int ADDR_W      = 19
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                mode,
  input  logic [COORD_W-1:0]  min_x,
  input  logic [COORD_W-1:0]  min_y,
  input  logic [COORD_W-1:0]  dx,
  input  logic [COORD_W-1:0]  dy,
  output logic                sol_start,
  output logic                sol_flush,
  output logic [COORD_W-1:0]  sol_c_re,
  output logic [COORD_W-1:0]  sol_c_im,
  input  logic                sol_done,
  input  logic [ITER_W-1:0]   sol_result,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic [ADDR_W-1:0]   pix_addr,
  output logic [RESULT_W-1:0] pix_value,
  output logic                busy,
  output logic                done
);

  localparam int COL_W = $clog2(NUM_COLUMNS + NUM_SOLVERS + 1);
  localparam int ROW_W = $clog2(NUM_ROWS + NUM_SOLVERS + 1);
  localparam logic [ADDR_W-1:0]  c_row_step   = ADDR_W'(NUM_SOLVERS * NUM_COLUMNS - (NUM_COLUMNS - 1));
  localparam logic [ADDR_W-1:0]  c_row0_addr  = ADDR_W'(SOLVER_ID * NUM_COLUMNS);
  localparam logic [COORD_W-1:0] c_sid        = COORD_W'(SOLVER_ID);
  localparam logic [COORD_W-1:0] c_nsol       = COORD_W'(NUM_SOLVERS);
  localparam logic [COORD_W-1:0] c_ncol       = COORD_W'(NUM_COLUMNS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state, w_next_state;
  logic                r_mode;
  logic [COORD_W-1:0]  r_min_x, r_dx, r_dy, r_stride_x, r_wrap_x, r_stride_y;
  logic [COORD_W-1:0]  r_x, r_y;
  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_row;
  logic [ADDR_W-1:0]   r_addr;
  logic [RESULT_W-1:0] r_value;
  logic                r_pix_valid, r_sol_flush;

  // First owned pixel, derived directly from the start-cycle inputs
  logic [COL_W-1:0]    w_first_col;
  logic [ROW_W-1:0]    w_first_row;
  logic [COORD_W-1:0]  w_first_x, w_first_y;
  logic [ADDR_W-1:0]   w_first_addr;
  logic                w_first_empty;

  assign w_first_col   = mode ? COL_W'(SOLVER_ID) : '0;
  assign w_first_row   = mode ? '0 : ROW_W'(SOLVER_ID);
  assign w_first_x     = mode ? min_x + c_sid * dx : min_x;
  assign w_first_y     = mode ? min_y : min_y + c_sid * dy;
  assign w_first_addr  = mode ? ADDR_W'(SOLVER_ID) : c_row0_addr;
  assign w_first_empty = (w_first_row >= ROW_W'(NUM_ROWS));

  logic [COL_W-1:0]    w_col_inc, w_nxt_col;
  logic [ROW_W-1:0]    w_nxt_row;
  logic [COORD_W-1:0]  w_nxt_x, w_nxt_y;
  logic [ADDR_W-1:0]   w_nxt_addr;
  logic                w_last;

  always_comb begin
    w_col_inc  = r_col + COL_W'(NUM_SOLVERS);
    w_nxt_col  = r_col;
    w_nxt_row  = r_row;
    w_nxt_x    = r_x;
    w_nxt_y    = r_y;
    w_nxt_addr = r_addr;
    if (!r_mode) begin
      if (r_col < COL_W'(NUM_COLUMNS - 1)) begin
        w_nxt_col  = r_col + 1'b1;
        w_nxt_x    = r_x + r_dx;
        w_nxt_addr = r_addr + 1'b1;
      end else begin
        w_nxt_col  = '0;
        w_nxt_x    = r_min_x;
        w_nxt_row  = r_row + ROW_W'(NUM_SOLVERS);
        w_nxt_y    = r_y + r_stride_y;
        w_nxt_addr = r_addr + c_row_step;
      end
    end else begin
      w_nxt_addr = r_addr + ADDR_W'(NUM_SOLVERS);
      if (w_col_inc >= COL_W'(NUM_COLUMNS)) begin
        w_nxt_col = w_col_inc - COL_W'(NUM_COLUMNS);
        w_nxt_x   = r_x + r_stride_x - r_wrap_x;
        w_nxt_row = r_row + 1'b1;
        w_nxt_y   = r_y + r_dy;
      end else begin
        w_nxt_col = w_col_inc;
        w_nxt_x   = r_x + r_stride_x;
      end
    end
  end

  assign w_last = (w_nxt_row >= ROW_W'(NUM_ROWS));

  logic [RESULT_W-1:0] w_value;
`ifdef PIXEL_SCHEDULER_SATURATE_EN
  logic [ITER_W-1:0] w_shifted;
  assign w_shifted = sol_result >> VALUE_SHIFT;
  assign w_value   = (|w_shifted[ITER_W-1:RESULT_W]) ? '1 : w_shifted[RESULT_W-1:0];
`else
  assign w_value = sol_result[VALUE_SHIFT+RESULT_W-1:VALUE_SHIFT];
`endif

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    sol_start    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next_state = w_first_empty ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        sol_start    = 1'b1;
        w_next_state = S_WAIT;
      end
      S_WAIT: if (sol_done) w_next_state = S_EMIT;
      S_EMIT: if (pix_ready) w_next_state = w_last ? S_DONE : S_ISSUE;
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) w_next_state = w_first_empty ? S_DONE : S_ISSUE;
      end
      default: w_next_state = S_IDLE;
    endcase
    if (abort) w_next_state = S_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mode      <= 1'b0;
      r_min_x     <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_stride_x  <= '0;
      r_wrap_x    <= '0;
      r_stride_y  <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_addr      <= '0;
      r_value     <= '0;
      r_pix_valid <= 1'b0;
      r_sol_flush <= 1'b0;
    end else begin
      r_sol_flush <= abort && (r_state == S_ISSUE || r_state == S_WAIT);
      if (abort) begin
        r_pix_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: if (start) begin
            r_mode     <= mode;
            r_min_x    <= min_x;
            r_dx       <= dx;
            r_dy       <= dy;
            r_stride_x <= c_nsol * dx;
            r_wrap_x   <= c_ncol * dx;
            r_stride_y <= c_nsol * dy;
            r_col      <= w_first_col;
            r_row      <= w_first_row;
            r_x        <= w_first_x;
            r_y        <= w_first_y;
            r_addr     <= w_first_addr;
          end
          S_WAIT: if (sol_done) begin
            r_value     <= w_value;
            r_pix_valid <= 1'b1;
          end
          S_EMIT: if (pix_ready) begin
            r_pix_valid <= 1'b0;
            r_col       <= w_nxt_col;
            r_row       <= w_nxt_row;
            r_x         <= w_nxt_x;
            r_y         <= w_nxt_y;
            r_addr      <= w_nxt_addr;
          end
          default: ;
        endcase
      end
    end
  end

  assign sol_flush = r_sol_flush;
  assign sol_c_re  = r_x;
  assign sol_c_im  = r_y;
  assign pix_valid = r_pix_valid;
  assign pix_addr  = r_addr;
  assign pix_value = r_value;

endmodule
`default_nettype wire

// File: doc/pixel_scheduler.md
Name: pixel_scheduler

Overview:
- Per-solver frame walker for the fractal renderer, and the successor to the fixed row-interleaved walker.
- Generates complex coordinates (c_re, c_im) for the pixels owned by one solver channel and drives an external escape-time solver via a start/done handshake.
- Emits each result as (linear address, value) on a valid/ready stream toward the frame-buffer arbiter.
- Supports row-interleaved and pixel-interleaved ownership, output backpressure, abort, and restart without reset.

Parameters:
- COORD_W, 27: width of signed fixed-point coordinates.
- ITER_W, 32: width of solver result.
- RESULT_W, 4: width of emitted pixel value.
- VALUE_SHIFT, 6: LSB index of solver result used for the pixel value.
- NUM_COLUMNS, 640: frame width; must be >= NUM_SOLVERS.
- NUM_ROWS, 480: frame height.
- NUM_SOLVERS, 1: number of channels sharing the frame.
- SOLVER_ID, 0: this channel's index, 0..NUM_SOLVERS-1.
- ADDR_W, 19: pixel address width; must hold NUM_COLUMNS*NUM_ROWS-1.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse; latches min_x, min_y, dx, dy, mode; begins a frame
- abort  in  1  pulse; cancels the frame in progress
- mode  in  1  0 = row interleave, 1 = pixel interleave
- min_x, min_y  in  COORD_W  signed origin
- dx, dy  in  COORD_W  signed pixel pitch
- sol_start  out  1  one-cycle request to solver
- sol_flush  out  1  one-cycle solver cancel on abort
- sol_c_re, sol_c_im  out  COORD_W  coordinate; stable from sol_start until sol_done
- sol_done  in  1  solver result valid (one cycle)
- sol_result  in  ITER_W  iteration count
- pix_valid  out  1  output stream valid
- pix_ready  in  1  output stream ready
- pix_addr  out  ADDR_W  row*NUM_COLUMNS+column
- pix_value  out  RESULT_W  pixel value
- busy  out  1  high in any state other than IDLE/DONE
- done  out  1  frame complete; held until start or reset

Behaviour:
- Reset values: sol_start, sol_flush, pix_valid, busy and done are 0; all other outputs are 0; state is IDLE.
- States: IDLE, ISSUE, WAIT, EMIT, DONE.
- IDLE/DONE, start=1:
  - Latch inputs.
  - Precompute stride_x = NUM_SOLVERS*dx, wrap_x = NUM_COLUMNS*dx, stride_y = NUM_SOLVERS*dy. All products truncate to COORD_W (two's complement).
  - First pixel, mode 0: column=0, row=SOLVER_ID, x=min_x, y=min_y+SOLVER_ID*dy.
  - First pixel, mode 1: column=SOLVER_ID, row=0, x=min_x+SOLVER_ID*dx, y=min_y.
  - addr = row*NUM_COLUMNS+column.
  - Clear done. If row >= NUM_ROWS, go to DONE (zero pixels); else go to ISSUE.
  - start is ignored in ISSUE, WAIT and EMIT.
- ISSUE: sol_start=1 for exactly one cycle; next state WAIT. First sol_start occurs the cycle after start is sampled.
- WAIT: on sol_done, register pix_value from sol_result and set pix_valid=1; next state EMIT. sol_done in any other state is ignored.
- EMIT:
  - pix_valid, pix_addr and pix_value stay stable until pix_ready.
  - Handshake cycle: drop pix_valid and advance the coordinate; go to ISSUE, or to DONE if this was the last pixel.
  - pix_ready while pix_valid=0 has no effect.
- Advance, mode 0:
  - If column < NUM_COLUMNS-1: column+1, x+=dx, addr+1.
  - Else: column=0, x=min_x, row+=NUM_SOLVERS, y+=stride_y, addr+=NUM_SOLVERS*NUM_COLUMNS-(NUM_COLUMNS-1).
- Advance, mode 1:
  - addr+=NUM_SOLVERS.
  - column+=NUM_SOLVERS, x+=stride_x.
  - If the new column >= NUM_COLUMNS (at most one wrap): column-=NUM_COLUMNS, x-=wrap_x, row+1, y+=dy.
- Last pixel: the advanced row >= NUM_ROWS.
- DONE: done=1, busy=0; remain until start.
- Abort, any state:
  - Next state IDLE; pix_valid cleared immediately.
  - sol_flush=1 for one cycle if abort occurred in ISSUE or WAIT.
  - done stays 0.
  - abort and start in the same cycle: abort wins.
- Reset mid-frame returns all outputs to reset values next cycle.
- Counters sized for NUM_COLUMNS+NUM_SOLVERS and NUM_ROWS+NUM_SOLVERS without overflow.

Optional Feature:
- Macro: PIXEL_SCHEDULER_SATURATE_EN.
- Defined: if sol_result >> VALUE_SHIFT exceeds 2^RESULT_W-1, pix_value = all ones; else the shifted bits.
- Undefined: pix_value = sol_result[VALUE_SHIFT+RESULT_W-1:VALUE_SHIFT] (truncation).

Test Plan:
- Mode 0 with NUM_COLUMNS=4, NUM_ROWS=3, NUM_SOLVERS=2, SOLVER_ID=1, min_x=100, min_y=200, dx=10, dy=5, pix_ready=1, solver done 3 cycles after each sol_start -> pixels at addr 4,5,6,7; sol_c_re 100,110,120,130; sol_c_im 205 throughout; then done=1.
- Mode 1, same parameters -> addr 1,3,5,7,9,11; c_re 110,130,110,130,110,130; c_im 200,200,205,205,210,210; then done.
- Backpressure: pix_ready held 0 for 5 cycles on the second pixel -> pix_addr/pix_value stable, no sol_start until the handshake; sequence unchanged.
- Abort while in WAIT -> sol_flush one cycle, pix_valid 0, IDLE, done 0. Subsequent start -> frame restarts at first pixel (addr 4 in mode 0).
- SOLVER_ID=3, NUM_SOLVERS=4, NUM_ROWS=3, mode 0 -> no sol_start; done=1 the cycle after start.
- sol_result=0x500 with RESULT_W=4, VALUE_SHIFT=6 -> pix_value 0x4 without macro, 0xF with PIXEL_SCHEDULER_SATURATE_EN.
